// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//   Lets two requesters share one APB completer. The arbiter is round-robin:
//   it picks an owner in IDLE, runs one SETUP/ACCESS phase pair, and then
//   spends one DONE cycle to return the result to the owner. The ACCESS phase
//   gives up after TIMEOUT wait cycles.
//
// Ports
//   pclk, presetn           clock; asynchronous active-low reset
//   req_valid/write[1:0]    per-requester request and direction (1 = write)
//   req_addr/wdata/strb     per-requester command, requester i in slice i
//   req_prot[5:0]           per-requester pprot, 3 bits each
//   gnt[1:0]                one-hot owner of the transfer in flight, 0 in IDLE
//   done[1:0]               one-cycle completion pulse to the owner
//   rdata, err              read data and completion status, valid with done
//   psel..pprot             APB requester-side outputs
//   prdata, pready, pslverr APB completer responses
// ---------------------------------------------------------------------------
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [1:0]                  req_valid,
    input  logic [1:0]                  req_write,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0] req_strb,
    input  logic [5:0]                  req_prot,
    output logic [1:0]                  gnt,
    output logic [1:0]                  done,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        err,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic [DATA_WIDTH-1:0]       pwdata,
    output logic [(DATA_WIDTH/8)-1:0]   pstrb,
    output logic [2:0]                  pprot,
    input  logic [DATA_WIDTH-1:0]       prdata,
    input  logic                        pready,
    input  logic                        pslverr
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    // Per-requester views of the packed command buses.
    logic [ADDR_WIDTH-1:0] addr_a  [2];
    logic [DATA_WIDTH-1:0] wdata_a [2];
    logic [STRB_WIDTH-1:0] strb_a  [2];
    logic [2:0]            prot_a  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign addr_a[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a[gi]  = req_strb[gi*STRB_WIDTH +: STRB_WIDTH];
        assign prot_a[gi]  = req_prot[gi*3 +: 3];
    end

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;

    // Pointer only breaks ties; a lone requester always wins.
    logic win;
    assign win = (req_valid == 2'b11) ? ptr_q : req_valid[1];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d  = SETUP;
                    owner_d  = win;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    psel_d   = 1'b1;
                    pwrite_d = req_write[win];
                    paddr_d  = addr_a[win];
                    pprot_d  = prot_a[win];
                    // Reads present all-zero write data and strobes.
                    pwdata_d = req_write[win] ? wdata_a[win] : '0;
                    pstrb_d  = req_write[win] ? strb_a[win]  : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = CNT_W'(TIMEOUT);
            end
            ACCESS: begin
                if (pready) begin
                    // A response on the final allowed cycle still completes normally.
                    state_d   = DONE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    err_d     = pslverr;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d   = DONE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    err_d     = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 2'b00;
                gnt_d   = 2'b00;
                ptr_d   = ~owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pstrb   = pstrb_q;
    assign pprot   = pprot_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
//   Randomised and directed transfers against a transaction-level model:
//   owner from the round-robin rule, ACCESS length from min(wait+1, TIMEOUT),
//   and result from the completer response or a timeout.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [1:0]        req_valid;
    logic [1:0]        req_write;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [2*SW-1:0]   req_strb;
    logic [5:0]        req_prot;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [DW-1:0]     rdata;
    logic              err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic [2:0]        pprot;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    always #5 pclk = ~pclk;

    apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Per-requester commands, set before each transfer.
    logic          cw [2];
    logic [AW-1:0] ca [2];
    logic [DW-1:0] cd [2];
    logic [SW-1:0] cs [2];
    logic [2:0]    cp [2];

    // Model state.
    int            ptr_m;
    logic [DW-1:0] rdata_m;
    int            xfer_no = 0;

    task automatic rand_cmds();
        for (int i = 0; i < 2; i++) begin
            cw[i] = 1'($urandom_range(0, 1));
            ca[i] = $urandom;
            cd[i] = $urandom;
            cs[i] = 4'($urandom_range(0, 15));
            cp[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_psel"},    psel,    0);
        check_val({tag, "_penable"}, penable, 0);
        check_val({tag, "_gnt"},     gnt,     0);
        check_val({tag, "_done"},    done,    0);
        check_val({tag, "_pwrite"},  pwrite,  0);
        check_val({tag, "_paddr"},   paddr,   0);
        check_val({tag, "_pwdata"},  pwdata,  0);
        check_val({tag, "_pstrb"},   pstrb,   0);
        check_val({tag, "_pprot"},   pprot,   0);
        check_val({tag, "_rdata"},   rdata,   0);
        check_val({tag, "_err"},     err,     0);
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            check_val("idle_psel", psel, 0);
            check_val("idle_gnt",  gnt,  0);
            check_val("idle_done", done, 0);
        end
    endtask

    // One whole transfer, entered and left at a negedge in IDLE.
    task automatic do_xfer(input logic [1:0] vld, input int wait_n, input bit rdy_ok,
                           input bit slv, input bit drop_mid, input logic [DW-1:0] fixed_pd,
                           input bit use_fixed);
        int            owner;
        bit            tmo;
        int            n_acc;
        logic [1:0]    oh;
        logic [DW-1:0] pd;
        logic [DW-1:0] exp_wd;
        logic [SW-1:0] exp_st;

        req_valid = vld;
        req_write = {cw[1], cw[0]};
        req_addr  = {ca[1], ca[0]};
        req_wdata = {cd[1], cd[0]};
        req_strb  = {cs[1], cs[0]};
        req_prot  = {cp[1], cp[0]};

        owner  = (vld == 2'b11) ? ptr_m : (vld[1] ? 1 : 0);
        oh     = (owner == 1) ? 2'b10 : 2'b01;
        tmo    = !(rdy_ok && wait_n < TO);
        n_acc  = tmo ? TO : wait_n + 1;
        exp_wd = cw[owner] ? cd[owner] : '0;
        exp_st = cw[owner] ? cs[owner] : '0;
        pd     = '0;

        @(negedge pclk);
        check_val("setup_psel",    psel,    1);
        check_val("setup_penable", penable, 0);
        check_val("setup_gnt",     gnt,     oh);
        check_val("setup_done",    done,    0);
        check_val("setup_pwrite",  pwrite,  cw[owner]);
        check_val("setup_paddr",   paddr,   ca[owner]);
        check_val("setup_pwdata",  pwdata,  exp_wd);
        check_val("setup_pstrb",   pstrb,   exp_st);
        check_val("setup_pprot",   pprot,   cp[owner]);

        for (int a = 0; a < n_acc; a++) begin
            @(negedge pclk);
            if (a == 0 && drop_mid) req_valid = req_valid & ~oh;
            check_val("acc_psel",    psel,    1);
            check_val("acc_penable", penable, 1);
            check_val("acc_gnt",     gnt,     oh);
            check_val("acc_done",    done,    0);
            check_val("acc_paddr",   paddr,   ca[owner]);
            check_val("acc_pwdata",  pwdata,  exp_wd);
            check_val("acc_pwrite",  pwrite,  cw[owner]);
            pd      = use_fixed ? fixed_pd : $urandom;
            prdata  = pd;
            pready  = rdy_ok && (a >= wait_n);
            pslverr = slv;
        end

        @(negedge pclk);
        if (!tmo && !cw[owner]) rdata_m = pd;
        check_val("done_psel",    psel,    0);
        check_val("done_penable", penable, 0);
        check_val("done_pulse",   done,    oh);
        check_val("done_gnt",     gnt,     oh);
        check_val("done_err",     err,     tmo ? 1 : slv);
        check_val("done_rdata",   rdata,   rdata_m);
        pready    = 1'b0;
        pslverr   = 1'b0;
        req_valid = req_valid & ~oh;
        ptr_m     = 1 - owner;

        @(negedge pclk);
        check_val("post_gnt",   gnt,   0);
        check_val("post_done",  done,  0);
        check_val("post_psel",  psel,  0);
        check_val("post_paddr", paddr, ca[owner]);
        check_val("post_pprot", pprot, cp[owner]);

        $display("xfer %0d: req=%b owner=%0d write=%0b addr=0x%08h acc_cycles=%0d timeout=%0b err_exp=%0b rdata_exp=0x%08h",
                 xfer_no, vld, owner, cw[owner], ca[owner], n_acc, tmo, tmo ? 1'b1 : slv, rdata_m);
        xfer_no++;
    endtask

    initial begin
        logic [1:0] v;
        presetn   = 1'b0;
        req_valid = 2'b00;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        ptr_m     = 0;
        rdata_m   = '0;

        repeat (3) @(negedge pclk);
        check_reset_outputs("rst");
        presetn = 1'b1;
        idle_cycles(2);

        // Single write from requester 0.
        rand_cmds();
        cw[0] = 1'b1; ca[0] = 32'h8; cd[0] = 32'hDEADBEEF; cs[0] = 4'hF;
        do_xfer(2'b01, 0, 1, 0, 0, '0, 0);

        // Contention: three transfers with both requesting.
        for (int i = 0; i < 3; i++) begin
            rand_cmds();
            do_xfer(2'b11, 0, 1, 0, 0, '0, 0);
        end

        // Read with three wait states; response lands on the last allowed cycle.
        rand_cmds();
        cw[1] = 1'b0;
        do_xfer(2'b10, 3, 1, 0, 0, 32'h12345678, 1);

        // Read timeout: rdata must keep the previous read value.
        rand_cmds();
        cw[0] = 1'b0;
        do_xfer(2'b01, 0, 0, 0, 0, '0, 0);

        // Slave error, then a clean transfer.
        rand_cmds();
        do_xfer(2'b01, 1, 1, 1, 0, '0, 0);
        rand_cmds();
        do_xfer(2'b01, 0, 1, 0, 0, '0, 0);

        // Requester withdraws mid-transfer; transfer still completes.
        rand_cmds();
        do_xfer(2'b10, 2, 1, 0, 1, '0, 0);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            rand_cmds();
            v = 2'($urandom_range(1, 3));
            do_xfer(v, $urandom_range(0, 5), $urandom_range(0, 9) != 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, '0, 0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        // Make the pointer favour requester 1, then reset during ACCESS.
        rand_cmds();
        do_xfer(2'b01, 0, 1, 0, 0, '0, 0);
        rand_cmds();
        req_valid = 2'b01;
        req_write = {cw[1], cw[0]};
        req_addr  = {ca[1], ca[0]};
        req_wdata = {cd[1], cd[0]};
        req_strb  = {cs[1], cs[0]};
        req_prot  = {cp[1], cp[0]};
        @(negedge pclk);
        @(negedge pclk);
        check_val("pre_rst_penable", penable, 1);
        presetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        req_valid = 2'b00;
        @(negedge pclk);
        presetn = 1'b1;
        ptr_m   = 0;
        rdata_m = '0;
        idle_cycles(3);

        // Pointer restarts at requester 0.
        rand_cmds();
        do_xfer(2'b11, 0, 1, 0, 0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
